// File: rtl/mem_pkg.sv
// Shared types and helpers for the IF/LS main-memory arbiter.
// FSM states, owner tags, RV32 load/store funct3 codes, alignment check.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Undefined widths (3,6,7) report as misaligned so they never touch mem.
    function automatic logic misaligned(
        input logic [2:0] funct3,
        input logic [1:0] addr_lo
    );
        logic m;
        case (funct3)
            LB, LBU:  m = 1'b0;
            LH, LHU:  m = addr_lo[0];
            LW:       m = (addr_lo != 2'b00);
            default:  m = 1'b1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates IF fetches and LS loads/stores onto one banked memory port.
// Ports: if_* fetch side, ls_* load/store side, mem_* memory command/data.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 32,
    parameter int LS_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              ls_req,
    input  logic              ls_write,
    input  logic [2:0]        ls_funct3,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic              mem_write,
    output logic [2:0]        mem_funct3,
    output logic [DATA_W-1:0] mem_din,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int CNT_W = $clog2(LS_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LS_BURST);

    state_t           state;
    state_t           state_nx;
    owner_t           owner;
    logic             cmd_write;
    logic             cmd_mis;
    logic [CNT_W-1:0] ls_cnt;

    logic arb_en;
    logic if_first;
    logic pick_ls;
    logic pick_if;
    logic resp;

    // Grants are suppressed during reset so nothing is accepted and lost.
    assign arb_en   = ((state == IDLE) || (state == RESP)) && !reset;
    assign if_first = if_req && (ls_cnt >= CNT_MAX);
    assign pick_ls  = arb_en && ls_req && !if_first;
    assign pick_if  = arb_en && if_req && !pick_ls;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (pick_ls || pick_if) ? ACCESS : IDLE;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = (pick_ls || pick_if) ? ACCESS : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs; write and rvalid are masked by reset so an aborted
    // access neither commits a store nor returns data.
    always_comb begin
        if_gnt    = pick_if;
        ls_gnt    = pick_ls;
        resp      = (state == RESP) && !reset;
        mem_write = (state == ACCESS) && cmd_write && !cmd_mis && !reset;
        if_rvalid = resp && (owner == OWN_IF);
        ls_rvalid = resp && (owner == OWN_LS);
        if_err    = if_rvalid && cmd_mis;
        ls_err    = ls_rvalid && cmd_mis;
        if_rdata  = '0;
        ls_rdata  = '0;
        if (if_rvalid && !cmd_mis) begin
            if_rdata = mem_dout;
        end
        if (ls_rvalid && !cmd_mis && !cmd_write) begin
            ls_rdata = mem_dout;
        end
    end

    // Command register: captured at grant, held through ACCESS and RESP
    // so the bank mux keeps selecting the accessed bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= OWN_IF;
            cmd_write  <= 1'b0;
            cmd_mis    <= 1'b0;
            mem_addr   <= '0;
            mem_funct3 <= '0;
            mem_din    <= '0;
        end else if (pick_ls) begin
            owner      <= OWN_LS;
            cmd_write  <= ls_write;
            cmd_mis    <= misaligned(ls_funct3, ls_addr[1:0]);
            mem_addr   <= ls_addr;
            mem_funct3 <= ls_funct3;
            mem_din    <= ls_wdata;
        end else if (pick_if) begin
            owner      <= OWN_IF;
            cmd_write  <= 1'b0;
            cmd_mis    <= misaligned(LW, if_addr[1:0]);
            mem_addr   <= if_addr;
            mem_funct3 <= LW;
            mem_din    <= '0;
        end
    end

    // Consecutive LS grants while IF is waiting; saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            ls_cnt <= '0;
        end else if (!if_req || pick_if) begin
            ls_cnt <= '0;
        end else if (pick_ls && (ls_cnt != CNT_MAX)) begin
            ls_cnt <= ls_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural banked BRAM.
// Expected responses are queued at grant and compared at rvalid.
module tb_mem_arbiter;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [12:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        ls_req;
    logic        ls_write;
    logic [2:0]  ls_funct3;
    logic [12:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_din;
    logic [12:0] mem_addr;
    logic [31:0] mem_dout;

    typedef struct {
        logic        own_ls;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   wr_cycles = 0;

    logic [31:0] ram [0:2047];
    logic [31:0] rd_q;

    mem_arbiter #(.ADDR_W(13), .DATA_W(32), .LS_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_write(ls_write), .ls_funct3(ls_funct3),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_write(mem_write), .mem_funct3(mem_funct3), .mem_din(mem_din),
        .mem_addr(mem_addr), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return 32'hC0DE0000 | 32'(i);
    endfunction

    // Synchronous BRAM model: word index addr[12:2], bank = addr[12:11].
    always @(posedge clk) begin
        if (mem_write) begin
            wr_cycles <= wr_cycles + 1;
            case (mem_funct3)
                SB: ram[mem_addr[12:2]][8*mem_addr[1:0] +: 8] <= mem_din[7:0];
                SH: ram[mem_addr[12:2]][16*mem_addr[1] +: 16] <= mem_din[15:0];
                default: ram[mem_addr[12:2]] <= mem_din;
            endcase
        end
        rd_q <= ram[mem_addr[12:2]];
    end
    assign mem_dout = rd_q;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        ls_req    = 1'b0;
        ls_write  = 1'b0;
        ls_funct3 = '0;
        ls_addr   = '0;
        ls_wdata  = '0;
    endtask

    // One request from issue to response, checking grant, the held
    // command in ACCESS, the response in RESP and the write count.
    task automatic run_xact(
        input logic        is_ls,
        input logic        wr,
        input logic [2:0]  f3,
        input logic [12:0] addr,
        input logic [31:0] wd,
        input logic [31:0] exp_data,
        input logic        exp_err
    );
        exp_t e;
        exp_t got_e;
        int   w0;
        bit   got;
        logic exp_wr;
        exp_wr = wr && !exp_err;
        if (is_ls) begin
            ls_req = 1'b1; ls_write = wr; ls_funct3 = f3;
            ls_addr = addr; ls_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (is_ls ? ls_gnt : if_gnt) got = 1'b1;
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL gnt_timeout addr=%h: no grant in 20 cycles", addr);
            idle_inputs();
            return;
        end
        e.own_ls = is_ls; e.data = exp_data; e.err = exp_err;
        sbq.push_back(e);
        w0 = wr_cycles;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (mem_addr !== addr || mem_write !== exp_wr ||
            mem_funct3 !== (is_ls ? f3 : LW) ||
            if_rvalid !== 1'b0 || ls_rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL access_cmd addr=%h wr=%b f3=%h rv=%b%b need addr=%h wr=%b",
                     mem_addr, mem_write, mem_funct3, if_rvalid, ls_rvalid,
                     addr, exp_wr);
        end
        @(negedge clk);
        n_cmp++;
        if ((is_ls ? ls_rvalid : if_rvalid) !== 1'b1 ||
            (is_ls ? if_rvalid : ls_rvalid) !== 1'b0) begin
            n_bad++;
            $display("FAIL rvalid_latency if_rv=%b ls_rv=%b need owner_ls=%b",
                     if_rvalid, ls_rvalid, is_ls);
            void'(sbq.pop_front());
        end else begin
            got_e = sbq.pop_front();
            n_cmp++;
            if ((is_ls ? ls_rdata : if_rdata) !== got_e.data ||
                (is_ls ? ls_err : if_err) !== got_e.err ||
                mem_addr !== addr || mem_write !== 1'b0) begin
                n_bad++;
                $display("FAIL resp_data addr=%h data=%h err=%b need data=%h err=%b",
                         addr, is_ls ? ls_rdata : if_rdata,
                         is_ls ? ls_err : if_err, got_e.data, got_e.err);
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if ((wr_cycles - w0) !== (exp_wr ? 1 : 0)) begin
            n_bad++;
            $display("FAIL write_count got=%0d need=%0d", wr_cycles - w0,
                     exp_wr ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        bit bad;
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_write} !== 5'b0)
                bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL reset_idle_pulses seen=1 need=0");
        end
        n_cmp++;
        if (mem_addr !== 13'h0 || mem_funct3 !== 3'h0 || mem_din !== 32'h0 ||
            if_rdata !== 32'h0 || ls_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_regs addr=%h f3=%h din=%h need all 0",
                     mem_addr, mem_funct3, mem_din);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_if_only();
        run_xact(1'b0, 1'b0, LW, 13'h0804, 32'h0, init_val(13'h0804 >> 2), 1'b0);
    endtask

    task automatic test_store_load();
        run_xact(1'b1, 1'b1, SW, 13'h1FFC, 32'hDEADBEEF, 32'h0, 1'b0);
        run_xact(1'b1, 1'b0, LW, 13'h1FFC, 32'h0, 32'hDEADBEEF, 1'b0);
    endtask

    // Both requesters held: expect LS x4 then IF, repeating, one grant
    // every other cycle.
    task automatic test_back_to_back();
        int   gcount;
        int   last_g;
        int   cyc;
        logic exp_ls;
        exp_t e;
        if_req = 1'b1; if_addr = 13'h0804;
        ls_req = 1'b1; ls_write = 1'b0; ls_funct3 = LW; ls_addr = 13'h0040;
        gcount = 0; last_g = -1; cyc = 0;
        for (int i = 0; i < 60 && gcount < 15; i++) begin
            @(negedge clk);
            cyc++;
            if (if_rvalid || ls_rvalid) begin
                e = sbq.pop_front();
                n_cmp++;
                if (ls_rvalid !== e.own_ls || if_rvalid === ls_rvalid ||
                    (e.own_ls ? ls_rdata : if_rdata) !== e.data) begin
                    n_bad++;
                    $display("FAIL b2b_resp rv=%b%b data=%h need ls=%b data=%h",
                             if_rvalid, ls_rvalid,
                             e.own_ls ? ls_rdata : if_rdata, e.own_ls, e.data);
                end
            end
            if (if_gnt || ls_gnt) begin
                exp_ls = (gcount % 5) != 4;
                n_cmp++;
                if (if_gnt === ls_gnt || ls_gnt !== exp_ls ||
                    (last_g >= 0 && cyc - last_g != 2)) begin
                    n_bad++;
                    $display("FAIL b2b_grant #%0d gnt=%b%b gap=%0d need ls=%b gap=2",
                             gcount, if_gnt, ls_gnt, cyc - last_g, exp_ls);
                end
                e.own_ls = ls_gnt;
                e.data   = ls_gnt ? init_val(13'h0040 >> 2)
                                  : init_val(13'h0804 >> 2);
                e.err    = 1'b0;
                sbq.push_back(e);
                last_g = cyc;
                gcount++;
            end
        end
        @(posedge clk); #1;
        idle_inputs();
        repeat (4) begin
            @(negedge clk);
            if ((if_rvalid || ls_rvalid) && sbq.size() > 0) begin
                e = sbq.pop_front();
                n_cmp++;
                if (ls_rvalid !== e.own_ls ||
                    (e.own_ls ? ls_rdata : if_rdata) !== e.data) begin
                    n_bad++;
                    $display("FAIL b2b_drain data=%h need %h",
                             e.own_ls ? ls_rdata : if_rdata, e.data);
                end
            end
        end
        n_cmp++;
        if (gcount != 15 || sbq.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_count grants=%0d left=%0d need 15/0",
                     gcount, sbq.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_misaligned();
        run_xact(1'b1, 1'b0, LW, 13'h0002, 32'h0, 32'h0, 1'b1);
        run_xact(1'b1, 1'b1, SH, 13'h0011, 32'h0000FFFF, 32'h0, 1'b1);
        run_xact(1'b1, 1'b0, LW, 13'h0000, 32'h0, init_val(0), 1'b0);
        run_xact(1'b1, 1'b0, LW, 13'h0010, 32'h0, init_val(4), 1'b0);
    endtask

    task automatic test_reset_abort();
        bit got;
        bit seen;
        int w0;
        ls_req = 1'b1; ls_write = 1'b1; ls_funct3 = SW;
        ls_addr = 13'h0100; ls_wdata = 32'h12345678;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ls_gnt) got = 1'b1;
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL abort_gnt_timeout no grant");
        end
        w0 = wr_cycles;
        @(posedge clk); #1;
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (mem_write !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_write got=%b need=0", mem_write);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ls_rvalid || if_rvalid) seen = 1'b1;
        end
        n_cmp++;
        if (seen || wr_cycles != w0) begin
            n_bad++;
            $display("FAIL abort_resp rvalid_seen=%b writes=%0d need 0/0",
                     seen, wr_cycles - w0);
        end
        @(posedge clk); #1;
        run_xact(1'b1, 1'b0, LW, 13'h0100, 32'h0, init_val(13'h0100 >> 2), 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = init_val(i);
        rd_q = '0;
        test_reset();
        test_if_only();
        test_store_load();
        test_back_to_back();
        test_misaligned();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
